// File: rtl/qa_qlp_mem_responder_if.sv
// QA driver CCI channel bundle between an AFU-side master and the QLP-side responder.
// Signal names follow the CCI channel naming so shims can be wired one-to-one.
interface qa_qlp_mem_responder_if #(
    parameter int CCI_DATA_WIDTH   = 512,
    parameter int CCI_RX_HDR_WIDTH = 18,
    parameter int CCI_TX_HDR_WIDTH = 61
);
    logic [CCI_TX_HDR_WIDTH-1:0] C0TxHdr;
    logic                        C0TxRdValid;
    logic                        C0TxAlmFull;
    logic [CCI_TX_HDR_WIDTH-1:0] C1TxHdr;
    logic [CCI_DATA_WIDTH-1:0]   C1TxData;
    logic                        C1TxWrValid;
    logic                        C1TxIrValid;
    logic                        C1TxAlmFull;
    logic [CCI_RX_HDR_WIDTH-1:0] C0RxHdr;
    logic [CCI_DATA_WIDTH-1:0]   C0RxData;
    logic                        C0RxRdValid;
    logic                        C0RxWrValid;
    logic                        C0RxCgValid;
    logic                        C0RxUgValid;
    logic                        C0RxIrValid;
    logic [CCI_RX_HDR_WIDTH-1:0] C1RxHdr;
    logic                        C1RxWrValid;
    logic                        C1RxIrValid;

    modport master (
        output C0TxHdr, C0TxRdValid, C1TxHdr, C1TxData, C1TxWrValid, C1TxIrValid,
        input  C0TxAlmFull, C1TxAlmFull, C0RxHdr, C0RxData, C0RxRdValid, C0RxWrValid,
               C0RxCgValid, C0RxUgValid, C0RxIrValid, C1RxHdr, C1RxWrValid, C1RxIrValid
    );

    modport slave (
        input  C0TxHdr, C0TxRdValid, C1TxHdr, C1TxData, C1TxWrValid, C1TxIrValid,
        output C0TxAlmFull, C1TxAlmFull, C0RxHdr, C0RxData, C0RxRdValid, C0RxWrValid,
               C0RxCgValid, C0RxUgValid, C0RxIrValid, C1RxHdr, C1RxWrValid, C1RxIrValid
    );
endinterface

// File: rtl/qa_qlp_mem_responder.sv
// QLP stand-in: sinks C0 reads / C1 writes into per-channel FIFOs, services them from a
// line memory and returns tagged responses a fixed LATENCY after each pop.
module qa_qlp_mem_responder #(
    parameter int CCI_DATA_WIDTH   = 512,
    parameter int CCI_RX_HDR_WIDTH = 18,
    parameter int CCI_TX_HDR_WIDTH = 61,
    parameter int CCI_TAG_WIDTH    = 14,
    parameter int MEM_ADDR_WIDTH   = 8,
    parameter int FIFO_DEPTH       = 16,
    parameter int ALM_FULL_SLACK   = 4,
    parameter int LATENCY          = 4
) (
    input  logic                         clk,
    input  logic                         resetb,
    qa_qlp_mem_responder_if.slave        bus,
    output logic                         ovf_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = CCI_TAG_WIDTH;
    localparam int AW = MEM_ADDR_WIDTH;
    localparam int DW = CCI_DATA_WIDTH;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [AW-1:0] addr;
    } rd_req_t;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;

    logic [DW-1:0] mem_q [2**AW];
    rd_req_t       c0_fifo_q [FIFO_DEPTH];
    wr_req_t       c1_fifo_q [FIFO_DEPTH];
    logic [PW-1:0] c0_wp_q, c0_rp_q, c1_wp_q, c1_rp_q;
    logic [CW-1:0] c0_cnt_q, c1_cnt_q;
    logic [LATENCY-1:0] c0_vld_q, c1_vld_q;
    logic [TW-1:0] c0_tag_q [LATENCY];
    logic [TW-1:0] c1_tag_q [LATENCY];
    logic [DW-1:0] c0_dat_q [LATENCY];

    logic    c0_pop, c1_pop, c0_full, c1_full;
    logic    c0_push, c1_push, c0_drop, c1_drop;
    rd_req_t c0_head;
    wr_req_t c1_head;
    logic    unused_ok;

    assign c0_pop  = (c0_cnt_q != '0);
    assign c1_pop  = (c1_cnt_q != '0);
    assign c0_full = (c0_cnt_q == CW'(FIFO_DEPTH));
    assign c1_full = (c1_cnt_q == CW'(FIFO_DEPTH));
    // A full FIFO that pops this cycle still has room for the incoming request.
    assign c0_push = bus.C0TxRdValid && (!c0_full || c0_pop);
    assign c1_push = bus.C1TxWrValid && (!c1_full || c1_pop);
    assign c0_drop = bus.C0TxRdValid && c0_full && !c0_pop;
    assign c1_drop = bus.C1TxWrValid && c1_full && !c1_pop;
    assign c0_head = c0_fifo_q[c0_rp_q];
    assign c1_head = c1_fifo_q[c1_rp_q];

    assign bus.C0TxAlmFull = (c0_cnt_q >= CW'(FIFO_DEPTH - ALM_FULL_SLACK));
    assign bus.C1TxAlmFull = (c1_cnt_q >= CW'(FIFO_DEPTH - ALM_FULL_SLACK));
    assign bus.C0RxWrValid = 1'b0;
    assign bus.C0RxCgValid = 1'b0;
    assign bus.C0RxUgValid = 1'b0;
    assign bus.C0RxIrValid = 1'b0;
    assign bus.C1RxIrValid = 1'b0;

    assign unused_ok = ^{bus.C0TxHdr[CCI_TX_HDR_WIDTH-1:TW+AW],
                         bus.C1TxHdr[CCI_TX_HDR_WIDTH-1:TW+AW], bus.C1TxIrValid};

    function automatic logic [CCI_RX_HDR_WIDTH-1:0] rsp_hdr(input logic [3:0] typ,
                                                             input logic [TW-1:0] tag);
        rsp_hdr = '0;
        rsp_hdr[CCI_RX_HDR_WIDTH-1 -: 4] = typ;
        rsp_hdr[TW-1:0] = tag;
    endfunction

    // Storage: FIFO bodies, line memory and the read-data pipe carry no reset.
    // The memory read and write share the pop edge, so a same-cycle read sees old data.
    always_ff @(posedge clk) begin
        if (c0_push) c0_fifo_q[c0_wp_q] <= '{tag: bus.C0TxHdr[TW-1:0], addr: bus.C0TxHdr[TW+AW-1:TW]};
        if (c1_push) c1_fifo_q[c1_wp_q] <= '{tag: bus.C1TxHdr[TW-1:0], addr: bus.C1TxHdr[TW+AW-1:TW],
                                             data: bus.C1TxData};
        if (c1_pop) mem_q[c1_head.addr] <= c1_head.data;
        c0_dat_q[0] <= mem_q[c0_head.addr];
        for (int i = 1; i < LATENCY; i++) c0_dat_q[i] <= c0_dat_q[i-1];
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            c0_wp_q         <= '0;
            c0_rp_q         <= '0;
            c1_wp_q         <= '0;
            c1_rp_q         <= '0;
            c0_cnt_q        <= '0;
            c1_cnt_q        <= '0;
            c0_vld_q        <= '0;
            c1_vld_q        <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                c0_tag_q[i] <= '0;
                c1_tag_q[i] <= '0;
            end
            bus.C0RxHdr     <= '0;
            bus.C0RxData    <= '0;
            bus.C0RxRdValid <= 1'b0;
            bus.C1RxHdr     <= '0;
            bus.C1RxWrValid <= 1'b0;
            ovf_err         <= 1'b0;
        end else begin
            if (c0_push) c0_wp_q <= c0_wp_q + PW'(1);
            if (c0_pop)  c0_rp_q <= c0_rp_q + PW'(1);
            if (c1_push) c1_wp_q <= c1_wp_q + PW'(1);
            if (c1_pop)  c1_rp_q <= c1_rp_q + PW'(1);
            c0_cnt_q <= c0_cnt_q + CW'(c0_push) - CW'(c0_pop);
            c1_cnt_q <= c1_cnt_q + CW'(c1_push) - CW'(c1_pop);

            c0_vld_q[0] <= c0_pop;
            c0_tag_q[0] <= c0_head.tag;
            c1_vld_q[0] <= c1_pop;
            c1_tag_q[0] <= c1_head.tag;
            for (int i = 1; i < LATENCY; i++) begin
                c0_vld_q[i] <= c0_vld_q[i-1];
                c0_tag_q[i] <= c0_tag_q[i-1];
                c1_vld_q[i] <= c1_vld_q[i-1];
                c1_tag_q[i] <= c1_tag_q[i-1];
            end

            bus.C0RxRdValid <= c0_vld_q[LATENCY-1];
            bus.C0RxHdr     <= c0_vld_q[LATENCY-1] ? rsp_hdr(4'h4, c0_tag_q[LATENCY-1]) : '0;
            bus.C0RxData    <= c0_vld_q[LATENCY-1] ? c0_dat_q[LATENCY-1] : '0;
            bus.C1RxWrValid <= c1_vld_q[LATENCY-1];
            bus.C1RxHdr     <= c1_vld_q[LATENCY-1] ? rsp_hdr(4'h1, c1_tag_q[LATENCY-1]) : '0;

            if (c0_drop || c1_drop) ovf_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_qa_qlp_mem_responder.sv
// Bench for qa_qlp_mem_responder: expected responses are queued when requests are driven
// and popped by a monitor when the responder answers.
module tb_qa_qlp_mem_responder;
    localparam int DW  = 512;
    localparam int RXW = 18;
    localparam int TXW = 61;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    logic ovf_err;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [13:0]   tag;
        logic [DW-1:0] data;
        bit            chk;
    } c0_exp_t;

    c0_exp_t     c0_q[$];
    logic [13:0] c1_q[$];

    localparam logic [DW-1:0] PAT_A5 = {64{8'hA5}};
    localparam logic [DW-1:0] PAT_11 = {64{8'h11}};
    localparam logic [DW-1:0] PAT_22 = {64{8'h22}};

    qa_qlp_mem_responder_if #(.CCI_DATA_WIDTH(DW), .CCI_RX_HDR_WIDTH(RXW),
                              .CCI_TX_HDR_WIDTH(TXW)) bus ();

    qa_qlp_mem_responder #(.CCI_DATA_WIDTH(DW), .CCI_RX_HDR_WIDTH(RXW), .CCI_TX_HDR_WIDTH(TXW),
                           .CCI_TAG_WIDTH(14), .MEM_ADDR_WIDTH(8), .FIFO_DEPTH(16),
                           .ALM_FULL_SLACK(4), .LATENCY(LAT)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    // Upper header bits are set to ones to confirm they are ignored.
    function automatic logic [TXW-1:0] mk_hdr(input logic [13:0] tag, input logic [7:0] addr);
        logic [TXW-1:0] h;
        h = '1;
        h[13:0]  = tag;
        h[21:14] = addr;
        return h;
    endfunction

    always @(negedge clk) begin
        if (resetb) begin
            if (bus.C0RxRdValid) begin
                checks++;
                if (c0_q.size() == 0) begin
                    errors++;
                    $display("FAIL c0_unexpected: got hdr %h with no request outstanding", bus.C0RxHdr);
                end else begin
                    c0_exp_t e;
                    e = c0_q.pop_front();
                    if (bus.C0RxHdr !== {4'h4, e.tag} || (e.chk && bus.C0RxData !== e.data)) begin
                        errors++;
                        $display("FAIL c0_rsp: hdr %h data %h, want hdr %h data %h",
                                 bus.C0RxHdr, bus.C0RxData, {4'h4, e.tag}, e.data);
                    end
                end
            end
            if (bus.C1RxWrValid) begin
                checks++;
                if (c1_q.size() == 0) begin
                    errors++;
                    $display("FAIL c1_unexpected: got hdr %h with no request outstanding", bus.C1RxHdr);
                end else begin
                    logic [13:0] t;
                    t = c1_q.pop_front();
                    if (bus.C1RxHdr !== {4'h1, t}) begin
                        errors++;
                        $display("FAIL c1_rsp: hdr %h, want %h", bus.C1RxHdr, {4'h1, t});
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.C0TxHdr     = '0;
        bus.C0TxRdValid = 1'b0;
        bus.C1TxHdr     = '0;
        bus.C1TxData    = '0;
        bus.C1TxWrValid = 1'b0;
        bus.C1TxIrValid = 1'b0;
    endtask

    task automatic test_reset();
        logic [2*RXW+DW+10:0] outs;
        clear_inputs();
        resetb = 1'b0;
        repeat (3) step();
        for (int c = 0; c < 21; c++) begin
            outs = {bus.C0TxAlmFull, bus.C1TxAlmFull, bus.C0RxHdr, bus.C0RxData, bus.C0RxRdValid,
                    bus.C0RxWrValid, bus.C0RxCgValid, bus.C0RxUgValid, bus.C0RxIrValid,
                    bus.C1RxHdr, bus.C1RxWrValid, bus.C1RxIrValid, ovf_err};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: outputs %h, want 0", c, outs);
            end
            resetb = 1'b1;
            step();
        end
    endtask

    task automatic test_write_read();
        bus.C1TxHdr     = mk_hdr(14'h123, 8'h05);
        bus.C1TxData    = PAT_A5;
        bus.C1TxWrValid = 1'b1;
        bus.C1TxIrValid = 1'b1;
        c1_q.push_back(14'h123);
        step();
        clear_inputs();
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (bus.C1RxWrValid !== (k == 5)) begin
                errors++;
                $display("FAIL wr_latency k=%0d: C1RxWrValid %b, want %b", k, bus.C1RxWrValid, k == 5);
            end
        end
        bus.C1TxIrValid = 1'b1;
        step();
        clear_inputs();
        bus.C0TxHdr     = mk_hdr(14'h3FF, 8'h05);
        bus.C0TxRdValid = 1'b1;
        c0_q.push_back('{tag: 14'h3FF, data: PAT_A5, chk: 1'b1});
        step();
        clear_inputs();
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (bus.C0RxRdValid !== (k == 5)) begin
                errors++;
                $display("FAIL rd_latency k=%0d: C0RxRdValid %b, want %b", k, bus.C0RxRdValid, k == 5);
            end
        end
        repeat (4) step();
        checks++;
        if (c1_q.size() != 0) begin
            errors++;
            $display("FAIL ir_ignored: %0d write responses still pending, want 0", c1_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int occ = 0;
        int first = -1;
        int last = -1;
        int npulse = 0;
        for (int c = 0; c < 30; c++) begin
            if (c < 16) begin
                bus.C0TxHdr     = mk_hdr(14'(c), 8'h05);
                bus.C0TxRdValid = 1'b1;
                c0_q.push_back('{tag: 14'(c), data: PAT_A5, chk: 1'b1});
            end else begin
                clear_inputs();
            end
            occ = occ + ((c < 16) ? 1 : 0) - ((occ > 0) ? 1 : 0);
            step();
            if (bus.C0RxRdValid) begin
                if (first < 0) first = c;
                last = c;
                npulse++;
            end
            checks++;
            if (bus.C0TxAlmFull !== (occ >= 12) || ovf_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_flow c=%0d: almfull %b ovf %b, want almfull %b ovf 0",
                         c, bus.C0TxAlmFull, ovf_err, occ >= 12);
            end
        end
        checks++;
        if (first != LAT + 1 || last != LAT + 16 || npulse != 16) begin
            errors++;
            $display("FAIL b2b_stream: first %0d last %0d pulses %0d, want %0d %0d 16",
                     first, last, npulse, LAT + 1, LAT + 16);
        end
    endtask

    task automatic test_same_cycle();
        bus.C1TxHdr     = mk_hdr(14'h010, 8'h10);
        bus.C1TxData    = PAT_11;
        bus.C1TxWrValid = 1'b1;
        c1_q.push_back(14'h010);
        step();
        clear_inputs();
        repeat (8) step();
        bus.C0TxHdr     = mk_hdr(14'h021, 8'h10);
        bus.C0TxRdValid = 1'b1;
        bus.C1TxHdr     = mk_hdr(14'h022, 8'h10);
        bus.C1TxData    = PAT_22;
        bus.C1TxWrValid = 1'b1;
        c0_q.push_back('{tag: 14'h021, data: PAT_11, chk: 1'b1});
        c1_q.push_back(14'h022);
        step();
        clear_inputs();
        bus.C0TxHdr     = mk_hdr(14'h023, 8'h10);
        bus.C0TxRdValid = 1'b1;
        c0_q.push_back('{tag: 14'h023, data: PAT_22, chk: 1'b1});
        step();
        clear_inputs();
        repeat (10) step();
        checks++;
        if (c0_q.size() != 0 || c1_q.size() != 0) begin
            errors++;
            $display("FAIL same_cycle_drain: pending rd %0d wr %0d, want 0 0", c0_q.size(), c1_q.size());
        end
    endtask

    task automatic test_overflow();
        int occ = 0;
        int drops = 0;
        force dut.c0_pop = 1'b0;
        for (int c = 0; c < 18; c++) begin
            bus.C0TxHdr     = mk_hdr(14'h100 + 14'(c), 8'h05);
            bus.C0TxRdValid = 1'b1;
            if (occ < 16) begin
                occ++;
                c0_q.push_back('{tag: 14'h100 + 14'(c), data: PAT_A5, chk: 1'b1});
            end else begin
                drops++;
            end
            step();
            checks++;
            if (bus.C0TxAlmFull !== (occ >= 12) || ovf_err !== (drops > 0)) begin
                errors++;
                $display("FAIL ovf_fill c=%0d: almfull %b ovf %b, want %b %b",
                         c, bus.C0TxAlmFull, ovf_err, occ >= 12, drops > 0);
            end
        end
        clear_inputs();
        release dut.c0_pop;
        repeat (30) step();
        checks++;
        if (c0_q.size() != 0 || ovf_err !== 1'b1 || bus.C0TxAlmFull !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drain: pending %0d ovf %b almfull %b, want 0 1 0",
                     c0_q.size(), ovf_err, bus.C0TxAlmFull);
        end
        resetb = 1'b0;
        #2;
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf_err %b after reset, want 0", ovf_err);
        end
        step();
        resetb = 1'b1;
        step();
    endtask

    task automatic test_reset_inflight();
        for (int c = 0; c < 3; c++) begin
            bus.C0TxHdr     = mk_hdr(14'h200 + 14'(c), 8'h05);
            bus.C0TxRdValid = 1'b1;
            c0_q.push_back('{tag: 14'h200 + 14'(c), data: PAT_A5, chk: 1'b1});
            step();
        end
        clear_inputs();
        resetb = 1'b0;
        c0_q.delete();
        step();
        resetb = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            checks++;
            if (bus.C0RxRdValid !== 1'b0) begin
                errors++;
                $display("FAIL inflight_drop c=%0d: C0RxRdValid %b, want 0", c, bus.C0RxRdValid);
            end
        end
        bus.C0TxHdr     = mk_hdr(14'h300, 8'h10);
        bus.C0TxRdValid = 1'b1;
        c0_q.push_back('{tag: 14'h300, data: PAT_22, chk: 1'b1});
        step();
        bus.C0TxHdr     = mk_hdr(14'h301, 8'h05);
        c0_q.push_back('{tag: 14'h301, data: PAT_A5, chk: 1'b1});
        step();
        clear_inputs();
        repeat (10) step();
        checks++;
        if (c0_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_read: pending %0d, want 0", c0_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_same_cycle();
        test_overflow();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
